pc_source_ctrl: RTL and testbench

//  Sequencer for the PC-source mux and the PC/EPC write enables. Accepts one PC-update

---
 rtl/pc_source_ctrl_if.sv | 27 ++
 rtl/pc_source_ctrl.sv | 130 +++++++++++++
 tb/tb_pc_source_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_source_ctrl_if.sv
// rtl/pc_source_ctrl_if.sv - request, PC-source and vector-fetch signals of pc_source_ctrl
// master: control unit / memory side; slave: the sequencer.
interface pc_source_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic        br_cond;
  logic [1:0]  exc_cause;
  logic        vec_valid;
  logic        req_ready;
  logic [2:0]  seletor;
  logic        pc_write;
  logic        epc_write;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        done;
  logic        vec_err;

  modport master (
    output req_valid, req_op, br_cond, exc_cause, vec_valid,
    input  req_ready, seletor, pc_write, epc_write, vec_rd, vec_addr, done, vec_err
  );

  modport slave (
    input  req_valid, req_op, br_cond, exc_cause, vec_valid,
    output req_ready, seletor, pc_write, epc_write, vec_rd, vec_addr, done, vec_err
  );
endinterface

// File: rtl/pc_source_ctrl.sv
// rtl/pc_source_ctrl.sv - PC-source mux / PC / EPC write sequencer with exception vector fetch
// Optional vector-read timeout enabled by defining PCSRC_VEC_TIMEOUT_EN.
module pc_source_ctrl #(
  parameter logic [31:0] VEC_BASE    = 32'd253,
  parameter int          VEC_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  pc_source_ctrl_if.slave  bus
);

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JR     = 3'b100;
  localparam logic [2:0] OP_EXC    = 3'b101;
  localparam logic [2:0] SEL_VEC   = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMMIT   = 3'd1,
    EXC_SAVE = 3'd2,
    EXC_RD   = 3'd3,
    EXC_LOAD = 3'd4,
    ERR      = 3'd5
  } state_t;

  if (VEC_TIMEOUT < 1) begin : g_bad_timeout
    $error("pc_source_ctrl: VEC_TIMEOUT must be >= 1");
  end

  state_t     state, state_n;
  logic [2:0] op_q;
  logic       br_q;
  logic [1:0] cause_q;
  logic       tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request fields are frozen at acceptance; later input wiggles are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      br_q    <= 1'b0;
      cause_q <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q    <= bus.req_op;
      br_q    <= bus.br_cond;
      cause_q <= bus.exc_cause;
    end
  end

`ifdef PCSRC_VEC_TIMEOUT_EN
  localparam int CW = $clog2(VEC_TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != EXC_RD) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // Last permitted EXC_RD cycle; vec_valid in this cycle still wins.
  assign tmo_hit     = (tmo_cnt == CW'(VEC_TIMEOUT - 1));
  assign bus.vec_err = (state == ERR);
`else
  assign tmo_hit     = 1'b0;
  assign bus.vec_err = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    bus.req_ready = 1'b0;
    bus.seletor   = 3'b000;
    bus.pc_write  = 1'b0;
    bus.epc_write = 1'b0;
    bus.vec_rd    = 1'b0;
    bus.vec_addr  = 32'd0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_n = (bus.req_op == OP_EXC) ? EXC_SAVE : COMMIT;
        end
      end
      COMMIT: begin
        bus.done = 1'b1;
        state_n  = IDLE;
        if (op_q <= OP_JR) begin
          bus.seletor  = op_q;
          bus.pc_write = !(op_q == OP_BRANCH && !br_q);
        end
      end
      EXC_SAVE: begin
        bus.epc_write = 1'b1;
        state_n       = EXC_RD;
      end
      EXC_RD: begin
        bus.vec_rd   = 1'b1;
        bus.vec_addr = VEC_BASE + {30'b0, cause_q};
        if (bus.vec_valid) begin
          state_n = EXC_LOAD;
        end else if (tmo_hit) begin
          state_n = ERR;
        end
      end
      EXC_LOAD: begin
        bus.seletor  = SEL_VEC;
        bus.pc_write = 1'b1;
        bus.done     = 1'b1;
        state_n      = IDLE;
      end
      ERR: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// tb/tb_pc_source_ctrl.sv - scoreboard bench for pc_source_ctrl
// Define PCSRC_VEC_TIMEOUT_EN to also exercise the vector-read timeout.
module tb_pc_source_ctrl;
  localparam logic [31:0] VB = 32'd253;
`ifdef PCSRC_VEC_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_source_ctrl_if bus ();

  pc_source_ctrl #(.VEC_BASE(VB), .VEC_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef enum int {EV_EPC = 0, EV_RD = 1, EV_DONE = 2} ev_t;
  typedef struct {
    ev_t         kind;
    int          cyc;
    logic [2:0]  sel;
    logic        pcw;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input ev_t k, input int c, input logic [2:0] s,
                               input logic p, input logic er, input logic [31:0] ad);
    exp_t e;
    e.kind = k; e.cyc = c; e.sel = s; e.pcw = p; e.err = er; e.addr = ad;
    sbq.push_back(e);
  endfunction

  task automatic take(input ev_t k, input string nm, output exp_t e, output bit ok);
    ok = 1'b0;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: unexpected event at cycle %0d, expected none", nm, cyc);
    end else begin
      e = sbq.pop_front();
      check({nm, " kind"}, 32'(k), 32'(e.kind));
      check({nm, " cycle"}, cyc, e.cyc);
      ok = (e.kind == k);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (rst_n) begin
      if (bus.epc_write) take(EV_EPC, "epc_write", e, ok);
      if (bus.vec_rd && !prev_rd) begin
        take(EV_RD, "vec_rd", e, ok);
        if (ok) check("vec_addr", bus.vec_addr, e.addr);
      end
      if (bus.done) begin
        take(EV_DONE, "done", e, ok);
        if (ok) begin
          check("seletor", 32'(bus.seletor), 32'(e.sel));
          check("pc_write", 32'(bus.pc_write), 32'(e.pcw));
          check("vec_err", 32'(bus.vec_err), 32'(e.err));
        end
      end else begin
        check("quiet strobes", {28'd0, bus.seletor, bus.pc_write}, 32'd0);
      end
    end
    prev_rd = bus.vec_rd;
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout: %0d events pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready before issue", 32'(bus.req_ready), 32'd1);
  endtask

  // d >= 0: vec_valid pulsed d cycles after vec_rd rises; d < 0: never.
  task automatic issue(input logic [2:0] op, input logic br, input logic [1:0] cause,
                       input int d, input bit flip, input logic [2:0] xs, input logic xp);
    int a;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.br_cond   = br;
    bus.exc_cause = cause;
    @(posedge clk);
    #1;
    a = cyc;
    bus.req_valid = 1'b0;
    if (flip) begin
      bus.br_cond   = ~br;
      bus.exc_cause = ~cause;
      bus.req_op    = 3'b000;
    end
    if (op == 3'b101) begin
      push(EV_EPC, a, 3'd0, 1'b0, 1'b0, 32'd0);
      push(EV_RD, a + 1, 3'd0, 1'b0, 1'b0, VB + 32'(cause));
      if (d >= 0) begin
        push(EV_DONE, a + 2 + d, 3'b101, 1'b1, 1'b0, 32'd0);
        repeat (2 + d) @(negedge clk);
        bus.vec_valid = 1'b1;
        @(negedge clk);
        bus.vec_valid = 1'b0;
      end else begin
        push(EV_DONE, a + 1 + TO, 3'b000, 1'b0, 1'b1, 32'd0);
      end
    end else begin
      push(EV_DONE, a, xs, xp, 1'b0, 32'd0);
    end
    drain();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.br_cond   = 1'b0;
    bus.exc_cause = 2'b00;
    bus.vec_valid = 1'b0;
    #12;
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst seletor", 32'(bus.seletor), 32'd0);
    check("rst pc_write", 32'(bus.pc_write), 32'd0);
    check("rst epc_write", 32'(bus.epc_write), 32'd0);
    check("rst vec_rd", 32'(bus.vec_rd), 32'd0);
    check("rst vec_addr", bus.vec_addr, 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst vec_err", 32'(bus.vec_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'b011, 1'b0, 2'd0, 0, 1'b0, 3'd3, 1'b1);
    check("ready after jump", 32'(bus.req_ready), 32'd1);
    issue(3'b001, 1'b0, 2'd0, 0, 1'b1, 3'd1, 1'b0);
    issue(3'b001, 1'b1, 2'd0, 0, 1'b0, 3'd1, 1'b1);
    issue(3'b000, 1'b0, 2'd0, 0, 1'b0, 3'd0, 1'b1);
    issue(3'b010, 1'b0, 2'd0, 0, 1'b0, 3'd2, 1'b1);
    issue(3'b100, 1'b1, 2'd0, 0, 1'b0, 3'd4, 1'b1);
    issue(3'b110, 1'b1, 2'd0, 0, 1'b0, 3'd0, 1'b0);
    issue(3'b111, 1'b1, 2'd0, 0, 1'b1, 3'd0, 1'b0);
    issue(3'b101, 1'b0, 2'd2, 3, 1'b1, 3'd0, 1'b0);
    issue(3'b101, 1'b0, 2'd0, 0, 1'b0, 3'd0, 1'b0);
    issue(3'b101, 1'b1, 2'd3, 1, 1'b1, 3'd0, 1'b0);

    // vec_valid while idle must not start anything.
    @(negedge clk);
    bus.vec_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle after stray vec_valid", 32'(bus.req_ready), 32'd1);

    // Back-to-back JR requests: accepted every second cycle.
    bus.req_op    = 3'b100;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("throughput ready", 32'(bus.req_ready), 32'((i % 2) == 0));
      if ((i % 2) == 0) push(EV_DONE, cyc + 1, 3'd4, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain();

    // Reset while waiting for the vector.
    begin
      int a;
      int n;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b101;
      bus.exc_cause = 2'd1;
      @(posedge clk);
      #1;
      a = cyc;
      bus.req_valid = 1'b0;
      push(EV_EPC, a, 3'd0, 1'b0, 1'b0, 32'd0);
      push(EV_RD, a + 1, 3'd0, 1'b0, 1'b0, VB + 32'd1);
      n = 0;
      while (!bus.vec_rd && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("vec_rd before reset", 32'(bus.vec_rd), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort req_ready", 32'(bus.req_ready), 32'd1);
      check("abort vec_rd", 32'(bus.vec_rd), 32'd0);
      check("abort pc_write", 32'(bus.pc_write), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drain();
    end
    issue(3'b011, 1'b0, 2'd0, 0, 1'b0, 3'd3, 1'b1);

`ifdef PCSRC_VEC_TIMEOUT_EN
    issue(3'b101, 1'b0, 2'd1, -1, 1'b0, 3'd0, 1'b0);
    issue(3'b101, 1'b0, 2'd2, TO - 1, 1'b0, 3'd0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
